// File: rtl/sap_display_pkg.sv
// Shared types and constants for the output display block.
// Holds the conversion FSM state, segment constants and the double-dabble step.
// Pure declarations; no timing or flow control of its own.
package sap_display_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int NUM_DIGITS = 4;
    localparam int BIN_W      = 8;
    localparam int BCD_W      = 12;
    localparam int WORK_W     = BCD_W + BIN_W;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    // One double-dabble iteration on the {bcd, binary} working register:
    // bump every BCD nibble that is 5 or more by 3, then shift left by one.
    function automatic logic [WORK_W-1:0] dd_step(input logic [WORK_W-1:0] v);
        logic [WORK_W-1:0] t;
        t = v;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (t[BIN_W + 4*i +: 4] >= 4'd5) begin
                t[BIN_W + 4*i +: 4] = t[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        return t << 1;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern (seg[0]=a .. seg[6]=g).
// Purely combinational, zero latency.
// No flow control; codes 10..15 decode to a blank digit.
module seg7_decode
    import sap_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Common-anode lookup for decimal digits
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/output_display.sv
// Converts an 8-bit register value to BCD and multiplexes it onto a 4-digit display.
// Conversion takes 8 cycles after the capture edge; scanning advances every SCAN_DIV cycles.
// No backpressure: input changes during a conversion are ignored and picked up afterwards.
// Optional feature: define SIGNED_DISPLAY_EN for two's-complement input with a minus sign.
module output_display
    import sap_display_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [BIN_W-1:0] data_in,
    output logic [6:0]       seg,
    output logic [3:0]       an,
    output logic             busy,
    output logic             valid
);

    localparam int               CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam int               IDX_W   = $clog2(NUM_DIGITS);

    state_t              state;
    state_t              state_nxt;
    logic                start;
    logic                done;
    logic [BIN_W-1:0]    captured;
    logic                pending;
    logic [WORK_W-1:0]   work;
    logic [WORK_W-1:0]   work_nxt;
    logic [2:0]          step;
    logic                conv_neg;
    logic [3:0]          hund;
    logic [3:0]          tens;
    logic [3:0]          ones;
    logic                disp_neg;
    logic [CNT_W-1:0]    scan_cnt;
    logic [IDX_W-1:0]    dig_idx;
    logic                neg_in;
    logic [BIN_W-1:0]    mag_in;
    logic [3:0]          nib;
    logic                dig_blank;
    logic                dig_minus;
    logic [6:0]          dec_seg;

`ifdef SIGNED_DISPLAY_EN
    // Negate negative inputs; 8'h80 maps to 128, which still fits in 8 bits
    assign neg_in = data_in[BIN_W-1];
    assign mag_in = neg_in ? (~data_in + 1'b1) : data_in;
`else
    assign neg_in = 1'b0;
    assign mag_in = data_in;
`endif

    assign work_nxt = dd_step(work);
    assign busy     = (state == CONV);

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: start on a new input value (or first cycle after reset), finish after 8 steps
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (pending || (data_in != captured)) begin
                    start     = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (step == 3'd7) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Conversion datapath; display registers only change on the final step
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            captured <= '0;
            pending  <= 1'b1;
            work     <= '0;
            step     <= '0;
            conv_neg <= 1'b0;
            hund     <= '0;
            tens     <= '0;
            ones     <= '0;
            disp_neg <= 1'b0;
            valid    <= 1'b0;
        end else if (start) begin
            captured <= data_in;
            pending  <= 1'b0;
            work     <= {{BCD_W{1'b0}}, mag_in};
            step     <= '0;
            conv_neg <= neg_in;
        end else if (state == CONV) begin
            work <= work_nxt;
            step <= step + 3'd1;
            if (done) begin
                hund     <= work_nxt[WORK_W-1 -: 4];
                tens     <= work_nxt[BIN_W + 4 +: 4];
                ones     <= work_nxt[BIN_W +: 4];
                disp_neg <= conv_neg;
                valid    <= 1'b1;
            end
        end
    end

    // Scan prescaler and digit index
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
        end else if (scan_cnt == CNT_MAX) begin
            scan_cnt <= '0;
            dig_idx  <= dig_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Pick the nibble for the active digit and apply leading-zero / sign blanking
    always_comb begin
        nib       = ones;
        dig_blank = 1'b0;
        dig_minus = 1'b0;
        case (dig_idx)
            2'd0: nib = ones;
            2'd1: begin
                nib       = tens;
                dig_blank = (hund == 4'd0) && (tens == 4'd0);
            end
            2'd2: begin
                nib       = hund;
                dig_blank = (hund == 4'd0);
            end
            default: begin
                dig_blank = ~disp_neg;
                dig_minus = disp_neg;
            end
        endcase
    end

    seg7_decode u_dec (
        .bcd (nib),
        .seg (dec_seg)
    );

    // Drive the display only once a conversion has completed
    always_comb begin
        seg = SEG_BLANK;
        an  = 4'hF;
        if (valid) begin
            an = ~(4'b0001 << dig_idx);
            if (dig_minus) begin
                seg = SEG_MINUS;
            end else if (dig_blank) begin
                seg = SEG_BLANK;
            end else begin
                seg = dec_seg;
            end
        end
    end

endmodule

// File: tb/tb_output_display.sv
// Self-checking bench for output_display with SCAN_DIV=4.
// Reference model derives digits with plain decimal arithmetic and the scan slot from elapsed cycles.
// Covers reset, directed and random values, mid-conversion input change and reset abort.
module tb_output_display;

    localparam int SCAN = 4;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;
    logic       valid;

    int         checks = 0;
    int         errors = 0;
    int         edges  = 0;
    bit         have_valid = 1'b0;
    logic [7:0] shown = 8'd0;

    logic [6:0] font [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    output_display #(.SCAN_DIV(SCAN)) dut (
        .clk     (clk),
        .clr     (clr),
        .data_in (data_in),
        .seg     (seg),
        .an      (an),
        .busy    (busy),
        .valid   (valid)
    );

    always #5 clk = ~clk;

    // Cycles since reset release, for the expected scan position
    always @(posedge clk or posedge clr) begin
        if (clr) edges <= 0;
        else     edges <= edges + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] exp_seg(input logic [7:0] v, input int pos);
        int mag;
        bit neg;
        neg = 1'b0;
        mag = int'(v);
`ifdef SIGNED_DISPLAY_EN
        if (v[7]) begin
            neg = 1'b1;
            mag = 256 - int'(v);
        end
`endif
        case (pos)
            0: return font[mag % 10];
            1: return (mag < 10)  ? 7'h7F : font[(mag / 10) % 10];
            2: return (mag < 100) ? 7'h7F : font[mag / 100];
            default: return neg ? 7'b0111111 : 7'h7F;
        endcase
    endfunction

    task automatic check_snapshot(input logic [7:0] v);
        int pos;
        logic [3:0] exp_an;
        pos = (edges / SCAN) % 4;
        exp_an = 4'hF;
        exp_an[pos] = 1'b0;
        chk($sformatf("an v=%0h pos=%0d", v, pos), 32'(an), 32'(exp_an));
        chk($sformatf("seg v=%0h pos=%0d", v, pos), 32'(seg), 32'(exp_seg(v, pos)));
    endtask

    task automatic check_display(input logic [7:0] v);
        for (int i = 0; i < 4 * SCAN; i++) begin
            check_snapshot(v);
            tick();
        end
    endtask

    // data_in must already hold v; the next edge is the capture edge
    task automatic run_conv(input logic [7:0] v, input int inj_at, input logic [7:0] v2);
        tick();
        chk("busy_e0", 32'(busy), 32'd1);
        chk("valid_e0", 32'(valid), 32'(have_valid));
        if (have_valid) check_snapshot(shown);
        for (int k = 1; k <= 8; k++) begin
            if (k == inj_at) data_in = v2;
            tick();
            chk($sformatf("busy_e%0d", k), 32'(busy), (k < 8) ? 32'd1 : 32'd0);
            if (k < 8) begin
                chk($sformatf("valid_e%0d", k), 32'(valid), 32'(have_valid));
                if (have_valid) check_snapshot(shown);
            end
        end
        have_valid = 1'b1;
        shown = v;
        chk("valid_done", 32'(valid), 32'd1);
        check_snapshot(v);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_seg"},   32'(seg),   32'h7F);
        chk({tag, "_an"},    32'(an),    32'hF);
        chk({tag, "_busy"},  32'(busy),  32'd0);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
    endtask

    logic [7:0] dir_vals [0:5] = '{8'd255, 8'hF6, 8'h80, 8'd100, 8'd10, 8'd5};

    initial begin
        logic [7:0] v;
        #1 clr = 1'b1;
        #2;
        check_reset_outputs("reset");
        repeat (2) tick();
        clr = 1'b0;

        // Zero right after reset: pending flag starts the conversion
        data_in = 8'd0;
        run_conv(8'd0, 0, 8'd0);
        check_display(8'd0);

        for (int i = 0; i < 6; i++) begin
            data_in = dir_vals[i];
            run_conv(dir_vals[i], 0, 8'd0);
            check_display(dir_vals[i]);
        end

        // Input change during conversion is deferred to a second conversion
        data_in = 8'd42;
        run_conv(8'd42, 3, 8'd7);
        run_conv(8'd7, 0, 8'd0);
        check_display(8'd7);

        for (int i = 0; i < 10; i++) begin
            v = 8'($urandom_range(0, 255));
            while (v == shown) v = 8'($urandom_range(0, 255));
            data_in = v;
            run_conv(v, 0, 8'd0);
            check_display(v);
        end

        // Reset in the middle of a conversion, then restart with the same input
        v = (shown == 8'd123) ? 8'd124 : 8'd123;
        data_in = v;
        repeat (4) tick();
        chk("busy_before_abort", 32'(busy), 32'd1);
        clr = 1'b1;
        #1;
        check_reset_outputs("abort");
        tick();
        check_reset_outputs("abort_hold");
        clr = 1'b0;
        have_valid = 1'b0;
        run_conv(v, 0, 8'd0);
        check_display(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_display.md
OUTPUT_DISPLAY -- requirements
Module: output_display

Interface
REQ-001 SHALL have parameter: SCAN_DIV, 1000, clk cycles per displayed digit (minimum 1).
REQ-002 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port: clr  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: data_in  input  8  value from the output register.
REQ-005 SHALL have port: seg  output  7  segments, active-low, seg[0]=a … seg[6]=g.
REQ-006 SHALL have port: an  output  4  digit enables, active-low; an[0]=ones, an[1]=tens, an[2]=hundreds, an[3]=sign.
REQ-007 SHALL have port: busy  output  1  conversion in progress.
REQ-008 SHALL have port: valid  output  1  display registers hold a completed conversion.

Function
REQ-009 SHALL run a two-state FSM: IDLE and CONV.
REQ-010 In IDLE, SHALL capture data_in on any edge where data_in differs from the captured value, or where the post-reset pending flag is set. That edge is E0; the FSM then enters CONV with busy=1.
REQ-011 In CONV, SHALL run one iterative double-dabble step per edge (add 3 to each BCD nibble >=5, then shift left 1), E1..E8, using a 3-bit step counter.
REQ-012 On E8, SHALL write hundreds/tens/ones to the display registers, set valid=1, clear busy and return to IDLE; busy is high for exactly 8 cycles.
REQ-013 SHALL ignore data_in changes during CONV; on return to IDLE a differing data_in starts a new conversion on the next edge.
REQ-014 SHALL run a prescaler 0..SCAN_DIV-1; on wrap, digit index advances 0→1→2→3→0. SCAN_DIV=1 advances every cycle.
REQ-015 SHALL drive an as one-hot-low for the current index when valid=1, else an=4'hF.
REQ-016 SHALL blank leading zeros: hundreds blank if 0; tens blank if hundreds and tens are both 0; ones always shown.
REQ-017 Blank digit SHALL be seg=7'h7F; minus SHALL be seg=7'b0111111; digit 0 SHALL be 7'b1000000 (standard common-anode hex decode for 0–9).

Reset
REQ-018 While clr=1, SHALL force asynchronously: state=IDLE, seg=7'h7F, an=4'hF, busy=0, valid=0, display registers=0, prescaler=0, digit index=0, captured value=0, pending flag=1.
REQ-019 Assertion of clr mid-conversion SHALL abort the conversion with no partial result visible.

Configuration
REQ-020 With macro SIGNED_DISPLAY_EN defined, SHALL treat data_in as two's complement: convert the magnitude (8'h80 → 128) and show minus on the sign digit when negative.
REQ-021 Without SIGNED_DISPLAY_EN, SHALL treat data_in as unsigned 0..255 and always blank the sign digit.

Structure
REQ-022 Package sap_display_pkg SHALL hold the FSM state enum, SEG_BLANK, SEG_MINUS, NUM_DIGITS=4 and BIN_W=8.
REQ-023 Combinational sub-module seg7_decode (4-bit BCD in, 7-bit active-low segments out) SHALL be used for digit decoding.

Verification
REQ-024 Scenario: release clr, data_in=8'd0 → busy for 8 cycles, then valid=1; ones=7'b1000000; tens and hundreds blank; sign blank.
REQ-025 Scenario: data_in=8'd255, unsigned build → digits 2,5,5; seg 7'b0100100, 7'b0010010, 7'b0010010.
REQ-026 Scenario, SIGNED_DISPLAY_EN: 8'hF6 → minus, blank, 1, 0; and 8'h80 → minus, 1, 2, 8.
REQ-027 Scenario: 8'd42 applied, changed to 8'd7 at E3 → 42 displayed after E8, then a second 8-cycle busy, then 7 with tens blank.
REQ-028 Scenario: clr pulsed at E4 → same cycle seg=7'h7F, an=4'hF, busy=0, valid=0; after release, a conversion restarts.
REQ-029 Scenario: SCAN_DIV=4, valid=1 → an cycles 1110, 1101, 1011, 0111, each held 4 cycles.
